// File: rtl/apb_mailbox_pkg.sv
// rtl/apb_mailbox_pkg.sv - register map and bit positions for the APB byte mailbox
package apb_mailbox_pkg;

    localparam logic [7:0] ADDR_ID      = 8'h00;
    localparam logic [7:0] ADDR_STATUS  = 8'h01;
    localparam logic [7:0] ADDR_CTRL    = 8'h02;
    localparam logic [7:0] ADDR_TXDATA  = 8'h03;
    localparam logic [7:0] ADDR_RXDATA  = 8'h04;
    localparam logic [7:0] ADDR_TXLEVEL = 8'h05;
    localparam logic [7:0] ADDR_RXLEVEL = 8'h06;

    localparam int ST_TX_EMPTY = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_RX_EMPTY = 2;
    localparam int ST_RX_FULL  = 3;
    localparam int ST_TX_OVF   = 4;
    localparam int ST_RX_UDF   = 5;

    localparam int CTRL_RX_IE = 0;
    localparam int CTRL_TX_IE = 1;

endpackage

// File: rtl/apb_mailbox_fifo.sv
// rtl/apb_mailbox_fifo.sv - power-of-two byte FIFO with a registered level count
module mailbox_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign empty = (count == '0);
    assign full  = (count == LW'(DEPTH));
    assign level = count;
    assign dout  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/apb_mailbox.sv
// rtl/apb_mailbox.sv - APB byte mailbox with TX/RX FIFOs, status, irq and wait states
module apb_mailbox
    import apb_mailbox_pkg::*;
#(
    parameter int         DEPTH       = 8,
    parameter int         WAIT_STATES = 0,
    parameter logic [7:0] ID_VALUE    = 8'hB8
) (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic       PSEL,
    input  logic       PENABLE,
    input  logic       PWRITE,
    input  logic [7:0] PADDR,
    input  logic [7:0] PWDATA,
    output logic [7:0] PRDATA,
    output logic       PREADY,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic       irq
);

    localparam int LW = $clog2(DEPTH + 1);

    logic [1:0]    wait_cnt;
    logic          armed;
    logic [1:0]    ctrl;
    logic          tx_ovf;
    logic          rx_udf;
    logic          tx_empty, tx_full, rx_empty, rx_full;
    logic [LW-1:0] tx_level, rx_level;
    logic [7:0]    rx_head;
    logic [7:0]    status;
    logic [7:0]    rd_mux;
    logic          wr_done, rd_done;
    logic          tx_push, tx_pop, rx_push, rx_pop;
    logic          tx_ovf_set, rx_udf_set;

    // armed is set by the setup phase so a transfer cut short by reset never completes later.
    assign PREADY  = PSEL & PENABLE & armed & (wait_cnt == 2'd0);
    assign wr_done = PREADY & PWRITE;
    assign rd_done = PREADY & ~PWRITE;

    assign tx_valid   = ~tx_empty;
    assign rx_ready   = ~rx_full;
    assign tx_push    = wr_done & (PADDR == ADDR_TXDATA);
    assign tx_pop     = tx_valid & tx_ready;
    assign tx_ovf_set = tx_push & tx_full & ~tx_pop;
    assign rx_push    = rx_valid & rx_ready;
    assign rx_pop     = rd_done & (PADDR == ADDR_RXDATA);
    assign rx_udf_set = rx_pop & rx_empty;

    mailbox_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk    (CLK),
        .resetn (RESETn),
        .push   (tx_push),
        .pop    (tx_pop),
        .din    (PWDATA),
        .dout   (tx_data),
        .empty  (tx_empty),
        .full   (tx_full),
        .level  (tx_level)
    );

    mailbox_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk    (CLK),
        .resetn (RESETn),
        .push   (rx_push),
        .pop    (rx_pop),
        .din    (rx_data),
        .dout   (rx_head),
        .empty  (rx_empty),
        .full   (rx_full),
        .level  (rx_level)
    );

    always_comb begin
        status = '0;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_TX_FULL]  = tx_full;
        status[ST_RX_EMPTY] = rx_empty;
        status[ST_RX_FULL]  = rx_full;
        status[ST_TX_OVF]   = tx_ovf;
        status[ST_RX_UDF]   = rx_udf;
    end

    always_comb begin
        rd_mux = '0;
        case (PADDR)
            ADDR_ID:      rd_mux = ID_VALUE;
            ADDR_STATUS:  rd_mux = status;
            ADDR_CTRL:    rd_mux = {6'b0, ctrl};
            ADDR_RXDATA:  rd_mux = rx_head;
            ADDR_TXLEVEL: rd_mux = 8'(tx_level);
            ADDR_RXLEVEL: rd_mux = 8'(rx_level);
            default:      rd_mux = '0;
        endcase
    end

    assign PRDATA = PREADY ? rd_mux : 8'h00;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            wait_cnt <= '0;
            armed    <= 1'b0;
            ctrl     <= '0;
            tx_ovf   <= 1'b0;
            rx_udf   <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (PSEL && !PENABLE) begin
                wait_cnt <= 2'(WAIT_STATES);
                armed    <= 1'b1;
            end else if (PSEL && PENABLE && !PREADY && wait_cnt != 2'd0) begin
                wait_cnt <= wait_cnt - 2'd1;
            end else if (PREADY) begin
                armed <= 1'b0;
            end

            if (wr_done && PADDR == ADDR_CTRL) ctrl <= PWDATA[1:0];

            // Clear is applied first so a coincident set event wins.
            tx_ovf <= (tx_ovf & ~(wr_done & (PADDR == ADDR_STATUS) & PWDATA[ST_TX_OVF])) | tx_ovf_set;
            rx_udf <= (rx_udf & ~(wr_done & (PADDR == ADDR_STATUS) & PWDATA[ST_RX_UDF])) | rx_udf_set;

            irq <= (ctrl[CTRL_RX_IE] & ~rx_empty) | (ctrl[CTRL_TX_IE] & tx_empty);
        end
    end

endmodule

// File: tb/tb_apb_mailbox.sv
// tb/tb_apb_mailbox.sv - self-checking bench for apb_mailbox against a queue-based model
module tb_apb_mailbox;

    localparam int         DEPTH = 8;
    localparam int         WS    = 2;
    localparam logic [7:0] ID    = 8'hB8;

    logic       CLK = 1'b0;
    logic       RESETn = 1'b1;
    logic       PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [7:0] PADDR = 8'h00, PWDATA = 8'h00;
    logic [7:0] PRDATA, tx_data;
    logic       PREADY, tx_valid, rx_ready, irq;
    logic       tx_ready, rx_valid;
    logic [7:0] rx_data;

    logic       rand_en = 1'b0;
    logic       tx_ready_d = 1'b0, rx_valid_d = 1'b0;
    logic [7:0] rx_data_d = 8'h00;
    logic       tx_ready_r = 1'b0, rx_valid_r = 1'b0;
    logic [7:0] rx_data_r = 8'h00;

    assign tx_ready = rand_en ? tx_ready_r : tx_ready_d;
    assign rx_valid = rand_en ? rx_valid_r : rx_valid_d;
    assign rx_data  = rand_en ? rx_data_r  : rx_data_d;

    int checks_m = 0, errors_m = 0, checks_d = 0, errors_d = 0;

    apb_mailbox #(.DEPTH(DEPTH), .WAIT_STATES(WS), .ID_VALUE(ID)) dut (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .irq      (irq)
    );

    always #5 CLK = ~CLK;

    function automatic int cmp(string name, int act, int exp);
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
            return 1;
        end
        return 0;
    endfunction

    // Behavioural model: FIFOs as queues, APB progress as a count of access cycles.
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    bit         m_ovf, m_udf, m_irq, in_xfer;
    bit   [1:0] m_ctrl;
    int         acc;

    always @(negedge CLK) begin : model
        bit         e_ready, tpop, rpush, ovf_set, udf_set, nirq, tx_full_pre, rx_empty_pre;
        logic [7:0] e_rd;
        if (!RESETn) begin
            txq.delete(); rxq.delete();
            m_ovf = 0; m_udf = 0; m_irq = 0; m_ctrl = 0; in_xfer = 0; acc = 0;
            checks_m += 6;
            errors_m += cmp("rst_pready", PREADY, 0) + cmp("rst_prdata", PRDATA, 0)
                      + cmp("rst_tx_valid", tx_valid, 0) + cmp("rst_tx_data", tx_data, 0)
                      + cmp("rst_rx_ready", rx_ready, 1) + cmp("rst_irq", irq, 0);
        end else begin
            e_ready = PSEL && PENABLE && in_xfer && acc == WS;
            e_rd = 8'h00;
            if (e_ready) begin
                case (PADDR)
                    8'h00: e_rd = ID;
                    8'h01: e_rd = {2'b00, m_udf, m_ovf, rxq.size() == DEPTH, rxq.size() == 0,
                                   txq.size() == DEPTH, txq.size() == 0};
                    8'h02: e_rd = {6'b0, m_ctrl};
                    8'h04: e_rd = (rxq.size() != 0) ? rxq[0] : 8'h00;
                    8'h05: e_rd = 8'(txq.size());
                    8'h06: e_rd = 8'(rxq.size());
                    default: e_rd = 8'h00;
                endcase
            end
            checks_m += 6;
            errors_m += cmp("pready", PREADY, e_ready) + cmp("prdata", PRDATA, e_rd)
                      + cmp("tx_valid", tx_valid, txq.size() != 0)
                      + cmp("tx_data", tx_data, (txq.size() != 0) ? txq[0] : 8'h00)
                      + cmp("rx_ready", rx_ready, rxq.size() < DEPTH)
                      + cmp("irq", irq, m_irq);

            nirq = (m_ctrl[0] && rxq.size() != 0) || (m_ctrl[1] && txq.size() == 0);
            tx_full_pre  = txq.size() == DEPTH;
            rx_empty_pre = rxq.size() == 0;
            tpop  = txq.size() != 0 && tx_ready;
            rpush = rx_valid && rxq.size() < DEPTH;
            ovf_set = 0; udf_set = 0;
            if (tpop) void'(txq.pop_front());
            if (e_ready && PWRITE) begin
                case (PADDR)
                    8'h01: begin
                        if (PWDATA[4]) m_ovf = 0;
                        if (PWDATA[5]) m_udf = 0;
                    end
                    8'h02: m_ctrl = PWDATA[1:0];
                    8'h03: if (!tx_full_pre || tpop) txq.push_back(PWDATA); else ovf_set = 1;
                    default: ;
                endcase
            end
            if (e_ready && !PWRITE && PADDR == 8'h04) begin
                if (!rx_empty_pre) void'(rxq.pop_front()); else udf_set = 1;
            end
            if (rpush) rxq.push_back(rx_data);
            if (ovf_set) m_ovf = 1;
            if (udf_set) m_udf = 1;
            m_irq = nirq;
            if (PSEL && !PENABLE) begin
                in_xfer = 1; acc = 0;
            end else if (PSEL && PENABLE && in_xfer) begin
                if (e_ready) in_xfer = 0; else acc++;
            end
        end
    end

    always @(posedge CLK) begin
        #1;
        if (rand_en) begin
            tx_ready_r = ($urandom_range(0, 3) == 0);
            rx_valid_r = ($urandom_range(0, 2) == 0);
            rx_data_r  = 8'($urandom);
        end
    end

    task automatic apb(input bit wr, input logic [7:0] addr, input logic [7:0] wd,
                       input bit pop_on_done, output logic [7:0] rd);
        bit done;
        int waits;
        @(posedge CLK); #1;
        PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = addr; PWDATA = wd;
        @(posedge CLK); #1;
        PENABLE = 1; waits = 0; done = 0; rd = 8'h00;
        for (int k = 0; k < 20 && !done; k++) begin
            if (pop_on_done && k == WS) tx_ready_d = 1;
            @(negedge CLK);
            if (PREADY) begin
                done = 1; rd = PRDATA;
            end else begin
                waits++;
            end
            @(posedge CLK); #1;
            tx_ready_d = 0;
        end
        PSEL = 0; PENABLE = 0;
        checks_d++;
        errors_d += cmp("apb_done", done, 1);
        checks_d++;
        errors_d += cmp("wait_cycles", waits, WS);
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] wd);
        logic [7:0] dummy;
        apb(1, addr, wd, 0, dummy);
    endtask

    task automatic rd_chk(input string name, input logic [7:0] addr, input logic [7:0] exp);
        logic [7:0] v;
        apb(0, addr, 8'h00, 0, v);
        checks_d++;
        errors_d += cmp(name, v, exp);
    endtask

    task automatic rx_send(input logic [7:0] b);
        @(posedge CLK); #1;
        rx_valid_d = 1; rx_data_d = b;
        @(posedge CLK); #1;
        rx_valid_d = 0;
    endtask

    task automatic drain(input logic [7:0] first, input int n);
        int got = 0;
        int cyc = 0;
        @(posedge CLK); #1;
        tx_ready_d = 1;
        while (got < n && cyc < 100) begin
            @(negedge CLK);
            if (tx_valid && tx_ready) begin
                checks_d++;
                errors_d += cmp("drain_data", tx_data, 8'(first + got));
                got++;
            end
            cyc++;
        end
        @(posedge CLK); #1;
        tx_ready_d = 0;
        checks_d++;
        errors_d += cmp("drain_count", got, n);
    endtask

    initial begin
        logic [7:0] v;
        int r;
        #1 RESETn = 0;
        repeat (2) @(posedge CLK);
        #1 RESETn = 1;

        rd_chk("id", 8'h00, 8'hB8);
        rd_chk("status_reset", 8'h01, 8'h05);
        rd_chk("txlevel_reset", 8'h05, 8'h00);
        checks_d += 2;
        errors_d += cmp("irq_reset", irq, 0) + cmp("rx_ready_reset", rx_ready, 1);

        for (int i = 0; i < 9; i++) wr(8'h03, 8'(8'h11 + i));
        rd_chk("txlevel_full", 8'h05, 8'h08);
        rd_chk("status_ovf", 8'h01, 8'h16);
        wr(8'h01, 8'h10);
        rd_chk("status_w1c", 8'h01, 8'h06);
        drain(8'h11, 8);

        rx_send(8'hA0);
        rx_send(8'hA1);
        rd_chk("rxlevel", 8'h06, 8'h02);
        wr(8'h02, 8'h01);
        repeat (2) @(negedge CLK);
        checks_d++;
        errors_d += cmp("irq_rx", irq, 1);
        rd_chk("rxdata0", 8'h04, 8'hA0);
        rd_chk("rxdata1", 8'h04, 8'hA1);
        repeat (2) @(negedge CLK);
        checks_d++;
        errors_d += cmp("irq_clear", irq, 0);
        rd_chk("rxdata_empty", 8'h04, 8'h00);
        rd_chk("status_udf", 8'h01, 8'h25);
        wr(8'h01, 8'h30);
        wr(8'h02, 8'h00);

        for (int i = 0; i < 8; i++) wr(8'h03, 8'(8'h30 + i));
        apb(1, 8'h03, 8'h38, 1, v);
        rd_chk("txlevel_pop_push", 8'h05, 8'h08);
        rd_chk("status_no_ovf", 8'h01, 8'h06);
        drain(8'h31, 8);

        for (int i = 0; i < 3; i++) wr(8'h03, 8'(8'h50 + i));
        rd_chk("txlevel_three", 8'h05, 8'h03);
        @(posedge CLK); #1;
        PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 8'h05;
        @(posedge CLK); #1;
        PENABLE = 1;
        @(negedge CLK);
        checks_d++;
        errors_d += cmp("wait_state_pready", PREADY, 0);
        #1 RESETn = 0;
        #1;
        checks_d += 2;
        errors_d += cmp("midreset_pready", PREADY, 0) + cmp("midreset_tx_valid", tx_valid, 0);
        @(posedge CLK); #1;
        PSEL = 0; PENABLE = 0;
        @(posedge CLK); #1;
        RESETn = 1;
        rd_chk("txlevel_after_reset", 8'h05, 8'h00);

        rand_en = 1;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4)      apb(1, 8'h03, 8'($urandom), 0, v);
            else if (r < 6) apb(0, 8'h04, 8'h00, 0, v);
            else            apb(1'($urandom), 8'($urandom_range(0, 8)), 8'($urandom), 0, v);
        end
        rand_en = 0;
        repeat (3) @(posedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks_m + checks_d, errors_m + errors_d);
        $finish;
    end

endmodule
